freq_list_loader: RTL and testbench

FREQ_LIST_LOADER -- requirements
Module: freq_list_loader

---
 rtl/freq_list_loader.sv | 175 +++++++++++++++++
 tb/tb_freq_list_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_list_loader.sv
// Streams one frequency-bin list into a ring buffer: clear pulse, registered writes, overflow
// drain and a settle delay before done. Optional idle timeout when LOADER_TIMEOUT_EN is defined.
module freq_list_loader #(
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned DW            = 4,
    parameter int unsigned SETTLE_CYCLES = 8
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT       = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic          ring_clr,
    output logic          ring_wr_en,
    output logic [DW-1:0] ring_din,
    output logic          busy,
    output logic          done,
    output logic [7:0]    loaded_count,
    output logic          overflow
`ifdef LOADER_TIMEOUT_EN
    ,
    output logic          err_timeout
`endif
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StClear  = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StSettle = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam int unsigned   SW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    DepthCount = 8'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wr_en_q, wr_en_d;
    logic [DW-1:0] din_q, din_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          accept;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned   TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          err_q, err_d;
`endif

    assign s_ready = (state_q == StLoad) || (state_q == StDrain);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        wr_en_d  = 1'b0;
        din_d    = din_q;
        settle_d = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StClear;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            StClear: begin
                state_d = StLoad;
            end
            StLoad: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    din_d   = s_data;
                    if (count_q != DepthCount) begin
                        count_d = count_q + 8'd1;
                    end
                    if (s_last) begin
                        state_d = StSettle;
                    end else if (count_q + 8'd1 >= DepthCount) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (accept) begin
                    ovf_d = 1'b1;
                    if (s_last) begin
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                // The final write lands in the first SETTLE cycle; done follows SETTLE_CYCLES later.
                if (settle_q == SettleLast) begin
                    state_d = StDone;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef LOADER_TIMEOUT_EN
        idle_d = '0;
        err_d  = err_q;
        if (((state_q == StIdle) || (state_q == StDone)) && start) begin
            err_d = 1'b0;
        end
        if (((state_q == StLoad) || (state_q == StDrain)) && !accept) begin
            if (idle_q == TimeoutLast) begin
                err_d   = 1'b1;
                state_d = StSettle;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            din_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            wr_en_q  <= wr_en_d;
            din_q    <= din_d;
            settle_q <= settle_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign err_timeout = err_q;
`endif

    // A write still pending when rst rises must not reach the ring.
    assign ring_wr_en   = wr_en_q & ~rst;
    assign ring_din     = din_q;
    assign ring_clr     = (state_q == StClear);
    assign busy         = (state_q == StClear) || (state_q == StLoad) ||
                          (state_q == StDrain) || (state_q == StSettle);
    assign done         = (state_q == StDone);
    assign loaded_count = count_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_freq_list_loader.sv
// Scoreboard bench for freq_list_loader; the timeout case is exercised when LOADER_TIMEOUT_EN
// is defined.
module tb_freq_list_loader;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned DW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          ring_clr;
    logic          ring_wr_en;
    logic [DW-1:0] ring_din;
    logic          busy;
    logic          done;
    logic [7:0]    loaded_count;
    logic          overflow;
`ifdef LOADER_TIMEOUT_EN
    logic          err_timeout;
`endif

    always #5 clk = ~clk;

    freq_list_loader #(
        .DEPTH         (DEPTH),
        .DW            (DW),
        .SETTLE_CYCLES (8)
`ifdef LOADER_TIMEOUT_EN
        ,
        .TIMEOUT       (16)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .ring_clr     (ring_clr),
        .ring_wr_en   (ring_wr_en),
        .ring_din     (ring_din),
        .busy         (busy),
        .done         (done),
        .loaded_count (loaded_count),
        .overflow     (overflow)
`ifdef LOADER_TIMEOUT_EN
        ,
        .err_timeout  (err_timeout)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    int            model_count;

    int cyc         = 0;
    int wr_cnt      = 0;
    int clr_cnt     = 0;
    int run_len     = 0;
    int last_wr_cyc = 0;
    int done_cyc    = 0;
    logic done_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ring write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (ring_wr_en) begin
            wr_cnt      <= wr_cnt + 1;
            run_len     <= run_len + 1;
            last_wr_cyc <= cyc;
            if (exp_q.size() == 0) check_eq("unexp_wr", 32'(ring_wr_en), 32'd0);
            else check_eq("wr_data", 32'(ring_din), 32'(exp_q.pop_front()));
        end else if (cyc != last_wr_cyc) begin
            if (run_len != 0 && !ring_wr_en && cyc == last_wr_cyc + 1) run_len <= run_len;
        end
        if (ring_clr) clr_cnt <= clr_cnt + 1;
        if (done && !done_prev) done_cyc <= cyc;
        done_prev <= done;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_count = 0;
        @(negedge clk);
        check_eq("clr_pulse", 32'(ring_clr), 32'd1);
        check_eq("clr_ready", 32'(s_ready), 32'd0);
        check_eq("clr_count", 32'(loaded_count), 32'd0);
        check_eq("clr_ovf", 32'(overflow), 32'd0);
        check_eq("clr_done", 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int  k   = 0;
        bit  acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = s_ready;
            k++;
            @(posedge clk); #1;
        end
        check_eq("beat_accept", 32'(acc), 32'd1);
        if (acc && model_count < DEPTH) begin
            exp_q.push_back(d);
            model_count++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic busy_start_cycle();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("busy_start_clr", 32'(ring_clr), 32'd0);
        check_eq("busy_start_rdy", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int wr_base;
        int clr_base;
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        model_count = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(s_ready), 32'd0);
        check_eq("rst_clr", 32'(ring_clr), 32'd0);
        check_eq("rst_wr", 32'(ring_wr_en), 32'd0);
        check_eq("rst_din", 32'(ring_din), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_count", 32'(loaded_count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Five back-to-back beats, done eight cycles after the final write.
        wr_base  = wr_cnt;
        clr_base = clr_cnt;
        pulse_start();
        run_len = 0;
        for (int i = 1; i <= 5; i++) send_beat(DW'(i), (i == 5));
        @(negedge clk);
        check_eq("t1_settle_rdy", 32'(s_ready), 32'd0);
        check_eq("t1_settle_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        wait_done(40);
        check_eq("t1_writes", 32'(wr_cnt - wr_base), 32'd5);
        check_eq("t1_run", 32'(run_len), 32'd5);
        check_eq("t1_clr", 32'(clr_cnt - clr_base), 32'd1);
        check_eq("t1_settle", 32'(done_cyc - last_wr_cyc), 32'd8);
        check_eq("t1_count", 32'(loaded_count), 32'd5);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_done_hold", 32'(done), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd0);

        // 130 beats: two beyond capacity are drained.
        wr_base = wr_cnt;
        pulse_start();
        for (int i = 1; i <= 130; i++) send_beat(DW'(i), (i == 130));
        wait_done(40);
        check_eq("t2_writes", 32'(wr_cnt - wr_base), 32'd128);
        check_eq("t2_ovf", 32'(overflow), 32'd1);
        check_eq("t2_count", 32'(loaded_count), 32'd128);

        // Exactly DEPTH beats with last: straight to SETTLE, no overflow.
        wr_base = wr_cnt;
        pulse_start();
        for (int i = 1; i <= 128; i++) send_beat(DW'(i * 3), (i == 128));
        @(negedge clk);
        check_eq("t3_settle_rdy", 32'(s_ready), 32'd0);
        check_eq("t3_settle_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        wait_done(40);
        check_eq("t3_writes", 32'(wr_cnt - wr_base), 32'd128);
        check_eq("t3_ovf", 32'(overflow), 32'd0);
        check_eq("t3_count", 32'(loaded_count), 32'd128);

        // Gapped beats with start pulses in the gaps.
        wr_base  = wr_cnt;
        clr_base = clr_cnt;
        pulse_start();
        send_beat(4'hA, 1'b0);
        busy_start_cycle();
        send_beat(4'hB, 1'b0);
        busy_start_cycle();
        send_beat(4'hC, 1'b1);
        wait_done(40);
        check_eq("t4_writes", 32'(wr_cnt - wr_base), 32'd3);
        check_eq("t4_clr", 32'(clr_cnt - clr_base), 32'd1);
        check_eq("t4_count", 32'(loaded_count), 32'd3);

        // Reset right after the third acceptance kills its write.
        wr_base = wr_cnt;
        pulse_start();
        send_beat(4'h1, 1'b0);
        send_beat(4'h2, 1'b0);
        send_beat(4'h3, 1'b0);
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_wr_supp", 32'(ring_wr_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_rdy", 32'(s_ready), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_count", 32'(loaded_count), 32'd0);
        check_eq("t5_din", 32'(ring_din), 32'd0);
        check_eq("t5_wr", 32'(ring_wr_en), 32'd0);
        @(posedge clk); #1;
        check_eq("t5_writes", 32'(wr_cnt - wr_base), 32'd2);
        pulse_start();
        send_beat(4'h4, 1'b0);
        send_beat(4'h5, 1'b1);
        wait_done(40);
        check_eq("t5_reload_cnt", 32'(loaded_count), 32'd2);

`ifdef LOADER_TIMEOUT_EN
        begin
            int k = 0;
            pulse_start();
            send_beat(4'h6, 1'b0);
            send_beat(4'h7, 1'b0);
            while (k < 40) begin
                @(negedge clk);
                k++;
                if (err_timeout) break;
            end
            check_eq("to_cycles", 32'(k), 32'd17);
            check_eq("to_settle_rdy", 32'(s_ready), 32'd0);
            check_eq("to_settle_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            wait_done(40);
            check_eq("to_err_sticky", 32'(err_timeout), 32'd1);
            check_eq("to_count", 32'(loaded_count), 32'd2);
        end
`endif

        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
